activation_cache: RTL and testbench

- Dilated-causal tap buffer for one layer. It sits between one layer's conv1d output (packed_out/out_v) and the next layer's conv1d inputs (packed_a0..packed_a3).
- Stores the history of accepted activation vectors in a ring buffer. For each new vector it presents four taps spaced DILATION samples apart.
- Taps older than the available history are zero (causal zero padding).

---
 rtl/activation_cache.sv | 118 +++++++++++
 tb/tb_activation_cache.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/activation_cache.sv
// Dilated-causal tap buffer: ring of past vectors, presents 4 taps DILATION apart (optional flush: ACTIVATION_CACHE_FLUSH_EN).
// Latency: out_v rises on the 5th edge counting the accepting edge; accepts are at least 6 cycles apart.
// Backpressure: in_ready only in IDLE; taps held with out_v high until out_ack.
module activation_cache #(
  parameter int W        = 16,
  parameter int D        = 4,
  parameter int DILATION = 1
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef ACTIVATION_CACHE_FLUSH_EN
  input  logic           flush,
`endif
  input  logic           in_v,
  output logic           in_ready,
  input  logic [D*W-1:0] packed_in,
  output logic [D*W-1:0] packed_a0,
  output logic [D*W-1:0] packed_a1,
  output logic [D*W-1:0] packed_a2,
  output logic [D*W-1:0] packed_a3,
  output logic           out_v,
  input  logic           out_ack
);

  localparam int L  = 3 * DILATION;
  localparam int PW = $clog2(L + 1);
  localparam int AW = PW + 1;
  localparam logic [AW-1:0] L_A   = AW'(L);
  localparam logic [AW-1:0] DIL_A = AW'(DILATION);
  localparam logic [PW-1:0] L_P   = PW'(L);
  localparam logic [PW-1:0] LAST  = PW'(L - 1);

  typedef enum logic [2:0] {IDLE, RD1, RD2, RD3, WR, VALID} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, fill;
  logic [D*W-1:0]  mem [L];
  logic [AW-1:0]   rd_dist, rd_sum;
  logic [PW-1:0]   rd_addr;
  logic            rd_mask;
  logic [D*W-1:0]  rd_dat;
  logic            flush_i;

`ifdef ACTIVATION_CACHE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Read distance k*DILATION; adding L first keeps the index non-negative.
  always_comb begin
    rd_dist = '0;
    case (state)
      RD1:     rd_dist = DIL_A;
      RD2:     rd_dist = DIL_A + DIL_A;
      RD3:     rd_dist = L_A;
      default: rd_dist = '0;
    endcase
    rd_sum  = {1'b0, wr_ptr} + L_A - rd_dist;
    rd_addr = (rd_sum >= L_A) ? PW'(rd_sum - L_A) : PW'(rd_sum);
    rd_mask = ({1'b0, fill} < rd_dist);
    rd_dat  = rd_mask ? '0 : mem[rd_addr];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!flush_i && in_v) state_nxt = RD1;
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = RD3;
      RD3:     state_nxt = WR;
      WR:      state_nxt = VALID;
      VALID:   if (out_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE) && !flush_i;
  assign out_v    = (state == VALID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      packed_a0 <= '0;
      packed_a1 <= '0;
      packed_a2 <= '0;
      packed_a3 <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (flush_i) begin
            wr_ptr <= '0;
            fill   <= '0;
          end else if (in_v) begin
            packed_a3 <= packed_in;
          end
        end
        RD1: packed_a2 <= rd_dat;
        RD2: packed_a1 <= rd_dat;
        RD3: packed_a0 <= rd_dat;
        WR: begin
          wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
          fill   <= (fill == L_P) ? fill : fill + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Memory is not reset; stale slots are hidden by fill.
  always_ff @(posedge clk) begin
    if (state == WR) mem[wr_ptr] <= packed_a3;
  end

endmodule

// File: tb/tb_activation_cache.sv
// Randomized scoreboard bench for activation_cache (W=16, D=2, DILATION=2).
module tb_activation_cache;
  localparam int TW   = 16;
  localparam int TD   = 2;
  localparam int TDIL = 2;
  localparam int DW   = TW * TD;

  typedef logic [DW-1:0] vec_t;
  typedef struct {vec_t t0; vec_t t1; vec_t t2; vec_t t3;} exp_t;

  logic clk = 1'b0;
  logic rst_n, in_v, out_ack, in_ready, out_v;
  vec_t packed_in, a0, a1, a2, a3;
`ifdef ACTIVATION_CACHE_FLUSH_EN
  logic flush = 1'b0;
`endif

  activation_cache #(.W(TW), .D(TD), .DILATION(TDIL)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ACTIVATION_CACHE_FLUSH_EN
    .flush(flush),
`endif
    .in_v(in_v), .in_ready(in_ready), .packed_in(packed_in),
    .packed_a0(a0), .packed_a1(a1), .packed_a2(a2), .packed_a3(a3),
    .out_v(out_v), .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  vec_t hist[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: tap j is the sample j*DILATION before the newest one, zero if never seen.
  function automatic vec_t tap(input int j);
    int idx;
    idx = hist.size() - 1 - j * TDIL;
    return (idx >= 0) ? hist[idx] : '0;
  endfunction

  // Monitor: pops one expectation per out_v window and checks taps stay put.
  exp_t cur;
  bit   seen = 1'b0;
  bit   have_cur = 1'b0;
  always @(negedge clk) begin
    if (!out_v) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        have_cur = 1'b0;
        total++; bad++;
        $display("FAIL unexpected_out_v actual=1 required=0");
      end else begin
        cur = exp_q.pop_front();
        have_cur = 1'b1;
        chk("tap_a0", a0, cur.t0);
        chk("tap_a1", a1, cur.t1);
        chk("tap_a2", a2, cur.t2);
        chk("tap_a3", a3, cur.t3);
      end
    end else if (have_cur) begin
      chk("taps_stable", {a0, a1, a2, a3}, {cur.t0, cur.t1, cur.t2, cur.t3});
    end
  end

  // Driver tasks are entered and left at posedge+1.
  task automatic accept(input vec_t v, output int waited);
    waited = 0;
    in_v = 1'b1;
    packed_in = v;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    in_v = 1'b0;
    hist.push_back(v);
    exp_q.push_back('{tap(3), tap(2), tap(1), tap(0)});
  endtask

  task automatic wait_valid();
    int e;
    e = 1;
    while (!out_v && e < 30) begin
      @(posedge clk); #1;
      e++;
    end
    chk("latency_edges", e, 5);
  endtask

  task automatic ack(input int hold, input bit pre, input vec_t nv);
    if (pre) begin
      in_v = 1'b1;
      packed_in = nv;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (pre) chk("in_ready_while_valid", in_ready, 0);
    end
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    chk("out_v_after_ack", out_v, 0);
    chk("in_ready_after_ack", in_ready, 1);
  endtask

  task automatic sample(input vec_t v, input int hold);
    int w;
    accept(v, w);
    wait_valid();
    ack(hold, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #7;
    hist.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    vec_t v;
    rst_n = 1'b0; in_v = 1'b0; out_ack = 1'b0; packed_in = '0;
    #12;
    chk("rst_out_v", out_v, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_a0", a0, 0);
    chk("rst_a1", a1, 0);
    chk("rst_a2", a2, 0);
    chk("rst_a3", a3, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // First sample after reset: only the current tap is populated.
    v = 32'h0001_0002;
    accept(v, w);
    wait_valid();
    chk("first_a3", a3, 32'h0001_0002);
    chk("first_a2", a2, 0);
    chk("first_a1", a1, 0);
    chk("first_a0", a0, 0);
    ack(0, 1'b0, '0);

    // Ramp {n,n} from fresh history covers warm-up masking.
    do_reset();
    for (int n = 1; n <= 7; n++) begin
      v = {16'(n), 16'(n)};
      accept(v, w);
      wait_valid();
      if (n == 7) begin
        chk("ramp7_a3", a3, {16'd7, 16'd7});
        chk("ramp7_a2", a2, {16'd5, 16'd5});
        chk("ramp7_a1", a1, {16'd3, 16'd3});
        chk("ramp7_a0", a0, {16'd1, 16'd1});
      end
      ack(0, 1'b0, '0);
    end

    // Random data through several pointer wraps, random ack delay.
    for (int n = 0; n < 20; n++) sample(vec_t'($urandom()), int'($urandom_range(0, 3)));

    // Consumer stall with a pending producer vector.
    accept(vec_t'($urandom()), w);
    wait_valid();
    v = vec_t'($urandom());
    ack(10, 1'b1, v);
    accept(v, w);
    chk("pending_accept_wait", w, 0);
    wait_valid();
    ack(0, 1'b0, '0);

    // Async reset during RD2 discards the partial read.
    accept(vec_t'($urandom()), w);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_v", out_v, 0);
    chk("midrst_taps", {a0, a1, a2, a3}, 0);
    void'(exp_q.pop_back());
    hist.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    sample(vec_t'($urandom()), 0);
    sample(vec_t'($urandom()), 1);

`ifdef ACTIVATION_CACHE_FLUSH_EN
    flush = 1'b1;
    in_v = 1'b1;
    packed_in = vec_t'($urandom());
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_no_accept", out_v, 0);
    hist.delete();
    sample(vec_t'($urandom()), 0);
    sample(vec_t'($urandom()), 0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
